// File: rtl/alu_issue_sequencer_pkg.sv
// Shared types and constants for the ALU issue sequencer.
package alu_seq_pkg;

    localparam int SEQ_W = 8;

    // Opcode [1:0] operation select
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    // One buffered command: 28 bits
    typedef struct packed {
        logic [7:0]       a;
        logic [7:0]       b;
        logic [3:0]       opcode;
        logic [SEQ_W-1:0] seq;
    } cmd_t;

    // The array has no operation for OP_NONE; it returns 0 and we flag it
    function automatic logic is_illegal(input logic [3:0] opcode);
        return opcode[1:0] == OP_NONE;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH x cmd_t, head visible combinationally, full/empty from count.
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  cmd_t          wdata,
    input  logic          pop,
    output cmd_t          rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage is not reset; only pointers and occupancy define validity
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Pointers wrap modulo DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_sequencer.sv
// Issue stage for the four-core ALU array: buffers commands, issues one at a
// time, waits out the array's registered latency and hands results downstream.
module alu_issue_sequencer
    import alu_seq_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_a,
    input  logic [7:0]    in_b,
    input  logic [3:0]    in_opcode,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [3:0]    alu_opcode,
    input  logic [15:0]   alu_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_result,
    output logic [3:0]    out_opcode,
    output logic [7:0]    out_seq,
    output logic          out_illegal,
    output logic [CW-1:0] count
);

    state_t           state;
    state_t           state_nxt;
    logic [SEQ_W-1:0] seq;
    logic [SEQ_W-1:0] issue_seq;
    cmd_t             head;
    logic             push;
    logic             pop;
    logic             capture;
    logic             release_out;
    logic             full;
    logic             empty;

    // in_ready depends only on occupancy, never on out_ready
    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ('{a: in_a, b: in_b, opcode: in_opcode, seq: seq}),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: ISSUE and WAIT are fixed single cycles covering array latency
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!empty) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  state_nxt = ST_HOLD;
            ST_HOLD:  if (out_ready) state_nxt = empty ? ST_IDLE : ST_ISSUE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: a drained result and the next pop share one edge
    always_comb begin
        pop         = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            ST_IDLE: pop = !empty;
            ST_WAIT: capture = 1'b1;
            ST_HOLD: begin
                release_out = out_ready;
                pop         = out_ready && !empty;
            end
            default: ;
        endcase
    end

    // Sequence number is stamped at push time and wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       seq <= '0;
        else if (push) seq <= seq + 1'b1;
    end

    // Issue registers: loaded on pop, held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            issue_seq  <= '0;
        end else if (pop) begin
            alu_a      <= head.a;
            alu_b      <= head.b;
            alu_opcode <= head.opcode;
            issue_seq  <= head.seq;
        end
    end

    // Result registers: captured at the end of WAIT, held until accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_opcode  <= '0;
            out_seq     <= '0;
            out_illegal <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_result  <= alu_result;
            out_opcode  <= alu_opcode;
            out_seq     <= issue_seq;
            out_illegal <= is_illegal(alu_opcode);
        end else if (release_out) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer: array model, expected-result queue, directed
// and randomized steps.
module tb_alu_issue_sequencer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_a;
    logic [7:0]    in_b;
    logic [3:0]    in_opcode;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [3:0]    alu_opcode;
    logic [15:0]   alu_result;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_result;
    logic [3:0]    out_opcode;
    logic [7:0]    out_seq;
    logic          out_illegal;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  op;
        logic [7:0]  seq;
        logic        ill;
    } exp_t;

    exp_t       q[$];
    int         mseq = 0;
    logic [7:0] last_seq = 8'hAA;
    int         cyc = 0;

    alu_issue_sequencer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_opcode   (in_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_result  (alu_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_opcode  (out_opcode),
        .out_seq     (out_seq),
        .out_illegal (out_illegal),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // What the array computes for a command: 16-bit arithmetic on zero-extended operands
    function automatic logic [15:0] ref_res(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op);
        case (op[1:0])
            2'b00:   return {8'd0, a} + {8'd0, b};
            2'b01:   return {8'd0, a} - {8'd0, b};
            2'b10:   return {8'd0, a} * {8'd0, b};
            default: return 16'd0;
        endcase
    endfunction

    // Array stand-in: one-cycle registered latency
    always @(posedge clk or posedge rst) begin
        if (rst) alu_result <= 16'd0;
        else     alu_result <= ref_res(alu_a, alu_b, alu_opcode);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: record accepted commands, compare every handed-off result in order
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (in_valid && in_ready) begin
                    q.push_back('{res: ref_res(in_a, in_b, in_opcode), op: in_opcode,
                                  seq: 8'(mseq), ill: (in_opcode[1:0] == 2'b11)});
                    mseq = (mseq + 1) % 256;
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out", {31'd0, out_valid}, 32'd0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("sb_result",  {16'd0, out_result}, {16'd0, e.res});
                        chk("sb_opcode",  {28'd0, out_opcode}, {28'd0, e.op});
                        chk("sb_seq",     {24'd0, out_seq},    {24'd0, e.seq});
                        chk("sb_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
                        last_seq = out_seq;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        q.delete();
        mseq = 0;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    // Present one command and hold it until accepted; returns just after the accepting edge
    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        bit ok = 0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_opcode = op;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("push_timeout", {31'd0, in_ready}, 32'd1);
        tick;
        in_valid = 1'b0;
    endtask

    // Returns at the falling edge where out_valid is first seen
    task automatic wait_out(input string tag);
        bit ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk(tag, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 400; k++) begin
            if (q.size() == 0) break;
            tick;
        end
        tick;
        tick;
        @(negedge clk);
        chk(tag, {29'd0, count}, 32'd0);
        tick;
    endtask

    initial begin
        int         ts[5];
        int         n;
        bit         acc;
        bit         rdy_pending;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_opcode = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready",    {31'd0, in_ready},    32'd1);
        chk("rst_out_valid",   {31'd0, out_valid},   32'd0);
        chk("rst_out_result",  {16'd0, out_result},  32'd0);
        chk("rst_out_opcode",  {28'd0, out_opcode},  32'd0);
        chk("rst_out_seq",     {24'd0, out_seq},     32'd0);
        chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
        chk("rst_alu_a",       {24'd0, alu_a},       32'd0);
        chk("rst_alu_b",       {24'd0, alu_b},       32'd0);
        chk("rst_alu_opcode",  {28'd0, alu_opcode},  32'd0);
        chk("rst_count",       {29'd0, count},       32'd0);

        // Single op with cycle-exact latency: accepted at edge E
        tick;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 8'd20;
        in_b      = 8'd5;
        in_opcode = 4'b0100;
        tick;                      // edge E
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_e_count", {29'd0, count}, 32'd1);
        chk("lat_e_valid", {31'd0, out_valid}, 32'd0);
        tick;                      // E+1: popped
        @(negedge clk);
        chk("lat_e1_count", {29'd0, count}, 32'd0);
        chk("lat_e1_alu_a", {24'd0, alu_a}, 32'd20);
        chk("lat_e1_alu_b", {24'd0, alu_b}, 32'd5);
        chk("lat_e1_alu_op", {28'd0, alu_opcode}, 32'd4);
        tick;                      // E+2: array captures
        @(negedge clk);
        chk("lat_e2_valid", {31'd0, out_valid}, 32'd0);
        tick;                      // E+3: result registered
        @(negedge clk);
        chk("lat_e3_valid",   {31'd0, out_valid},   32'd1);
        chk("lat_e3_result",  {16'd0, out_result},  32'd25);
        chk("lat_e3_seq",     {24'd0, out_seq},     32'd0);
        chk("lat_e3_illegal", {31'd0, out_illegal}, 32'd0);
        tick;

        // Multiply at full width, then subtraction wrapping below zero
        push(8'd255, 8'd255, 4'b0010);
        wait_out("mul_timeout");
        chk("mul_result", {16'd0, out_result}, 32'h0000FE01);
        tick;
        push(8'd3, 8'd5, 4'b1101);
        wait_out("sub_timeout");
        chk("sub_result", {16'd0, out_result}, 32'h0000FFFE);
        tick;

        // Illegal op is issued and flagged; the next command proceeds
        push(8'h37, 8'h11, 4'b1011);
        wait_out("ill_timeout");
        chk("ill_result",  {16'd0, out_result},  32'd0);
        chk("ill_flag",    {31'd0, out_illegal}, 32'd1);
        tick;
        push(8'd9, 8'd7, 4'b1000);
        wait_out("post_ill_timeout");
        chk("post_ill_result", {16'd0, out_result},  32'd16);
        chk("post_ill_flag",   {31'd0, out_illegal}, 32'd0);
        tick;

        // Back-pressure: DEPTH+1 commands with downstream stalled
        do_reset;
        for (int i = 0; i < DEPTH + 1; i++)
            push(8'($urandom), 8'($urandom), 4'($urandom));
        @(negedge clk);
        chk("bp_count_full", {29'd0, count},    32'(DEPTH));
        chk("bp_in_ready",   {31'd0, in_ready}, 32'd0);
        tick;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid",  {31'd0, out_valid},  32'd1);
            chk("bp_hold_result", {16'd0, out_result}, {16'd0, q[0].res});
            chk("bp_hold_seq",    {24'd0, out_seq},    {24'd0, q[0].seq});
            chk("bp_hold_ready",  {31'd0, in_ready},   32'd0);
            tick;
        end
        out_ready   = 1'b1;
        n           = 0;
        rdy_pending = 0;
        for (int k = 0; k < 60 && n < 5; k++) begin
            @(negedge clk);
            if (rdy_pending) begin
                chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
                rdy_pending = 0;
            end
            if (out_valid && out_ready) begin
                ts[n] = cyc;
                if (n == 0) rdy_pending = 1;
                n++;
            end
            tick;
        end
        chk("bp_result_cnt", 32'(n), 32'd5);
        for (int i = 1; i < 5; i++)
            chk("bp_spacing", 32'(ts[i] - ts[i-1]), 32'd3);

        // Randomized traffic with random downstream stalls
        acc = 0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || acc) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_a      = 8'($urandom);
                in_b      = 8'($urandom);
                in_opcode = 4'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            tick;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("rand_drain_count");

        // Sequence number wrap: 257th command carries seq 0
        do_reset;
        out_ready = 1'b1;
        for (int i = 0; i < 257; i++)
            push(8'($urandom), 8'($urandom), 4'($urandom));
        drain("wrap_drain_count");
        chk("seq_wrap", {24'd0, last_seq}, 32'd0);

        // Reset while in WAIT with three commands queued
        do_reset;
        push(8'd1, 8'd1, 4'b0000);
        wait_out("rm_first_timeout");
        tick;
        push(8'h5A, 8'h03, 4'b0100);
        push(8'h11, 8'h22, 4'b0000);
        push(8'h33, 8'h44, 4'b0001);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 8'h55;
        in_b      = 8'h66;
        in_opcode = 4'b0010;
        tick;                      // HOLD -> ISSUE, push and pop together
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("rm_count_issue", {29'd0, count}, 32'd3);
        tick;                      // now in WAIT
        chk("rm_alu_a_wait", {24'd0, alu_a}, 32'h5A);
        rst = 1'b1;
        #1;
        chk("rm_valid_now", {31'd0, out_valid}, 32'd0);
        chk("rm_count_now", {29'd0, count},     32'd0);
        chk("rm_ready_now", {31'd0, in_ready},  32'd1);
        q.delete();
        mseq = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("rm_no_stale", {31'd0, out_valid}, 32'd0);
            tick;
        end
        push(8'd1, 8'd2, 4'b1100);
        wait_out("rm_new_timeout");
        chk("rm_new_seq",    {24'd0, out_seq},    32'd0);
        chk("rm_new_result", {16'd0, out_result}, 32'd3);
        tick;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_sequencer.md
# alu_issue_sequencer

Upstream issue stage for the four-core ALU array (`multicore`). It accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO. It issues one command at a time to the array's `A`/`B`/`opcode` inputs, waits out the array's one-cycle registered latency, and captures `result`. Each result is presented downstream with its opcode, a sequence number and an illegal-op flag, under a second valid/ready handshake.

## Interface
- `DEPTH`, default 4: command FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  FIFO can accept; equals `count < DEPTH`. No combinational dependence on `out_ready`.
- `in_a`  in  8  operand A.
- `in_b`  in  8  operand B.
- `in_opcode`  in  4  `[3:2]` selects core, `[1:0]` selects op (00 add, 01 sub, 10 mul, 11 none).
- `alu_a`  out  8  registered, to array `A`.
- `alu_b`  out  8  registered, to array `B`.
- `alu_opcode`  out  4  registered, to array `opcode`.
- `alu_result`  in  16  array `result`, valid in WAIT state.
- `out_valid`  out  1  result held for downstream.
- `out_ready`  in  1  downstream accepts.
- `out_result`  out  16  captured `alu_result`.
- `out_opcode`  out  4  opcode of that result.
- `out_seq`  out  8  sequence number assigned at FIFO push.
- `out_illegal`  out  1  `out_opcode[1:0] == 2'b11`.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Push: on `in_valid && in_ready`, write {a, b, opcode, seq} to FIFO tail, then increment `seq`. `seq` is 8-bit and wraps 255→0.
- A push while full is not accepted (`in_ready`=0); the upstream holds its command.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE: if FIFO non-empty, pop head, load `alu_*` registers, go to ISSUE. Otherwise stay in IDLE.
- ISSUE: one cycle. `alu_*` remain stable; the array registers its result at the closing edge. Go to WAIT.
- WAIT: one cycle. At the closing edge, capture `alu_result` into `out_result` and copy opcode, seq and illegal into the `out_*` registers. Set `out_valid`=1 and go to HOLD.
- HOLD: hold all `out_*` stable while `out_valid && !out_ready`.
  - On `out_ready` with FIFO non-empty: clear `out_valid`, pop the next command, load `alu_*`, go to ISSUE (same edge).
  - On `out_ready` with FIFO empty: clear `out_valid`, go to IDLE.
- `alu_*` hold their last issued values outside ISSUE and WAIT.
- Push and pop in the same cycle are both honoured; `count` is unchanged.
- An illegal op is still issued. The array returns 0, and the block flags it via `out_illegal`; it is not dropped.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_result`=0, `out_opcode`=0, `out_seq`=0, `out_illegal`=0, `alu_a`/`alu_b`/`alu_opcode`=0, `count`=0, state=IDLE, `seq`=0, FIFO pointers=0.
- Reset asserted mid-operation discards all buffered and in-flight commands immediately. No output is produced for them.
- Latency, empty block: a command accepted at edge E is popped at E+1. The array captures at E+2 and `out_valid` rises after E+3.
- Throughput: one result per 3 cycles with `out_ready` held high.
- `in_ready` deasserts the cycle after the DEPTH-th outstanding push. It reasserts the cycle after the first pop.
- FIFO pointers wrap modulo DEPTH. Full/empty are derived from `count`.

## Structure
- Package `alu_seq_pkg` holds:
  - state enum (IDLE, ISSUE, WAIT, HOLD);
  - `OP_ADD`/`OP_SUB`/`OP_MUL`/`OP_NONE` 2-bit constants;
  - command struct {a[7:0], b[7:0], opcode[3:0], seq[7:0]};
  - `SEQ_W`=8.
- Sub-module `alu_cmd_fifo`: synchronous-write FIFO, DEPTH×28 bits, with push/pop/count and async reset. The FSM, issue registers and output registers live in the top.

## Test plan
- Single op: push A=8'd20, B=8'd5, opcode=4'b0100 → after E+3, `out_valid`=1, `out_result`=16'd25, `out_seq`=0, `out_illegal`=0.
- Multiply and sub wrap: push A=255, B=255, op=xx10 → `out_result`=16'hFE01. Push A=3, B=5, op=xx01 → result per array subtraction width (16'hFFFE); the bench checks it against the array model.
- Back-pressure: fill DEPTH+1 commands with `out_ready`=0 → `in_ready`=0 at `count`=DEPTH. Hold `out_ready` low 10 cycles → `out_*` stable. Release → results arrive in push order, 3 cycles apart, with `seq` 0..4.
- Illegal op: push opcode=4'b1011 → `out_result`=0, `out_illegal`=1, and the next command proceeds normally.
- Seq wrap: push 257 commands → the 257th result has `out_seq`=0.
- Reset mid-op: assert `rst` while in WAIT with 3 commands queued → immediately `out_valid`=0 and `count`=0. After release, no stale result appears, and a new push yields `out_seq`=0.
